// File: rtl/cic_comp_fir_if.sv
// Sample-stream bundle between the CIC decimator output and the droop
// compensation FIR, plus the FIR's status and debug observation points.
//
// Signals:
//   en_in    strobe, 1 clock per accepted input sample
//   in       signed input sample, meaningful only while en_in=1
//   en_out   strobe, 1 clock, out was updated on the edge that raised it
//   out      signed filtered/decimated sample, holds between strobes
//   overrun  sticky flag: a computation start was dropped
//   state    FSM state of the FIR, for observation only
//
// Handshake: strobe-only, no backpressure. A transfer happens on every
// rising clk edge where the strobe is 1; the receiver must take it. There is
// no ready; a producer that strobes faster than the FIR can start
// computations is reported through overrun instead of being stalled.
interface cic_comp_fir_if #(
    parameter int width = 9
);
    logic                    en_in;
    logic signed [width-1:0] in;
    logic                    en_out;
    logic signed [width-1:0] out;
    logic                    overrun;
    logic [2:0]              state;

    // slave: the FIR itself
    modport slave (
        input  en_in, in,
        output en_out, out, overrun, state
    );

    // master: the sample source / observer
    modport master (
        output en_in, in,
        input  en_out, out, overrun, state
    );
endinterface

// File: rtl/cic_comp_fir.sv
// Decimate-by-2 CIC droop-compensation FIR.
// Fixed 7-tap symmetric filter h = {-1, 0, 9, 16, 9, 0, -1} (DC gain 32,
// output scaled by 2^-5). Every second accepted sample starts a serial
// pre-added MAC over a snapshot of the window; the result is rounded half
// up, saturated to the sample width and emitted with a one-clock en_out.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    cic_comp_fir_if.slave: en_in/in in, en_out/out/overrun/state out
module cic_comp_fir #(
    parameter int width = 9
) (
    input  logic           clk,
    input  logic           reset,
    cic_comp_fir_if.slave  bus
);
    localparam int PW = width + 1;   // pre-add width
    localparam int AW = width + 6;   // accumulator width, sum|h| = 36 < 2^6

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MAC0 = 3'd1;
    localparam logic [2:0] MAC1 = 3'd2;
    localparam logic [2:0] MAC2 = 3'd3;
    localparam logic [2:0] MAC3 = 3'd4;
    localparam logic [2:0] OUT  = 3'd5;

    localparam logic signed [AW-1:0] YMAX = AW'((2 ** (width - 1)) - 1);
    localparam logic signed [AW-1:0] YMIN = AW'(-(2 ** (width - 1)));

    // Free-running delay line; together with the incoming sample it forms
    // the 7-sample window, so the oldest tap never needs its own register.
    logic signed [width-1:0] x [0:5];
    // Window frozen at the start edge; the MAC reads only this copy.
    logic signed [width-1:0] s [0:6];

    logic                    phase;
    logic [2:0]              state;
    logic signed [AW-1:0]    acc;
    logic signed [width-1:0] out_r;
    logic                    en_out_r;
    logic                    overrun_r;

    logic                    start_req;
    logic signed [PW-1:0]    pre;
    logic signed [5:0]       coef;
    logic signed [AW-1:0]    term;
    logic signed [AW-1:0]    rnd;
    logic signed [AW-1:0]    shifted;
    logic signed [width-1:0] y_sat;

    // The 2nd, 4th, ... accepted sample since reset asks for a computation.
    assign start_req = bus.en_in & phase;

    // One symmetric tap pair per MAC state.
    always_comb begin
        pre  = '0;
        coef = '0;
        case (state)
            MAC0: begin
                pre  = {s[0][width-1], s[0]} + {s[6][width-1], s[6]};
                coef = -6'sd1;
            end
            MAC1: begin
                pre  = {s[1][width-1], s[1]} + {s[5][width-1], s[5]};
                coef = 6'sd0;
            end
            MAC2: begin
                pre  = {s[2][width-1], s[2]} + {s[4][width-1], s[4]};
                coef = 6'sd9;
            end
            MAC3: begin
                pre  = {s[3][width-1], s[3]};
                coef = 6'sd16;
            end
            default: begin
                pre  = '0;
                coef = '0;
            end
        endcase
        term = AW'(pre) * AW'(coef);
    end

    // Round half up, arithmetic shift by 5, then clip to the sample range.
    always_comb begin
        rnd     = acc + AW'(16);
        shifted = rnd >>> 5;
        if (shifted > YMAX) begin
            y_sat = YMAX[width-1:0];
        end else if (shifted < YMIN) begin
            y_sat = YMIN[width-1:0];
        end else begin
            y_sat = shifted[width-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 1'b0;
            acc       <= '0;
            out_r     <= '0;
            en_out_r  <= 1'b0;
            overrun_r <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                x[i] <= '0;
            end
            for (int i = 0; i < 7; i++) begin
                s[i] <= '0;
            end
        end else begin
            en_out_r <= 1'b0;

            // The delay line and phase advance on every sample, even one
            // whose computation is dropped by an overrun.
            if (bus.en_in) begin
                x[0] <= bus.in;
                for (int i = 1; i < 6; i++) begin
                    x[i] <= x[i-1];
                end
                phase <= ~phase;
            end

            if (start_req && (state != IDLE)) begin
                overrun_r <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_req) begin
                        s[0] <= bus.in;
                        for (int i = 1; i < 7; i++) begin
                            s[i] <= x[i-1];
                        end
                        acc   <= '0;
                        state <= MAC0;
                    end
                end
                MAC0: begin
                    acc   <= acc + term;
                    state <= MAC1;
                end
                MAC1: begin
                    acc   <= acc + term;
                    state <= MAC2;
                end
                MAC2: begin
                    acc   <= acc + term;
                    state <= MAC3;
                end
                MAC3: begin
                    acc   <= acc + term;
                    state <= OUT;
                end
                OUT: begin
                    out_r    <= y_sat;
                    en_out_r <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.en_out  = en_out_r;
    assign bus.out     = out_r;
    assign bus.overrun = overrun_r;
    assign bus.state   = state;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir: directed impulse/DC/saturation/
// reset/overrun sequences plus randomized strobe traffic, all checked every
// cycle against a window-level model of the filter.
module tb_cic_comp_fir;
    localparam int W = 9;

    logic clk = 1'b0;
    logic reset;

    always #2 clk = ~clk;

    cic_comp_fir_if #(.width(W)) bus ();

    cic_comp_fir #(.width(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit cmp_on = 1'b0;

    // ---------------- model state ----------------
    logic [W-1:0] exp_q[$];     // expected out values, in order
    int           due_q[$];     // clock edge after which each is expected
    logic [W-1:0] hold_exp;     // value out must hold between strobes
    bit           ovr_exp;
    int           hist[6];      // previously accepted samples, [0] newest
    bit           ph;
    int           busy_until;   // first edge at which a new start is taken
    logic [W-1:0] got_q[$];     // values seen on en_out, for literal checks

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Filter output for a window w[0] (newest) .. w[6] (oldest).
    function automatic int fir(input int w[7]);
        int h[7];
        int acc;
        int y;
        h = '{-1, 0, 9, 16, 9, 0, -1};
        acc = 0;
        for (int k = 0; k < 7; k++) acc += h[k] * w[k];
        y = (acc + 16) >>> 5;
        if (y > (2 ** (W - 1)) - 1) y = (2 ** (W - 1)) - 1;
        if (y < -(2 ** (W - 1))) y = -(2 ** (W - 1));
        return y;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        due_q.delete();
        hold_exp   = '0;
        ovr_exp    = 1'b0;
        ph         = 1'b0;
        busy_until = 0;
        for (int k = 0; k < 6; k++) hist[k] = 0;
    endtask

    // A sample v accepted at clock edge e.
    task automatic model_accept(input int v, input int e);
        logic signed [W-1:0] t;
        int vs;
        int win[7];
        t  = v[W-1:0];
        vs = t;
        if (ph) begin
            if (e >= busy_until) begin
                win[0] = vs;
                for (int k = 1; k < 7; k++) win[k] = hist[k-1];
                exp_q.push_back(W'(fir(win)));
                due_q.push_back(e + 5);
                busy_until = e + 6;
            end else begin
                ovr_exp = 1'b1;
            end
        end
        for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = vs;
        ph = ~ph;
    endtask

    // ---------------- clock/edge counter ----------------
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
        end
    end

    // ---------------- compare process ----------------
    initial begin
        bit due;
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                due = (due_q.size() > 0) && (due_q[0] == edge_n);
                chk("en_out", {31'd0, bus.en_out}, {31'd0, due});
                if (due) begin
                    hold_exp = exp_q.pop_front();
                    void'(due_q.pop_front());
                end
                if (bus.en_out === 1'b1) got_q.push_back(bus.out);
                chk("out", $signed(bus.out), $signed(hold_exp));
                chk("overrun", {31'd0, bus.overrun}, {31'd0, ovr_exp});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit rst, input bit en, input int v);
        @(negedge clk);
        #1;
        reset     = rst;
        bus.en_in = rst ? 1'b0 : en;
        bus.in    = W'(v);
        if (rst) model_clear();
        else if (en) model_accept(v, edge_n + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) cyc(1'b1, 1'b0, 0);
    endtask

    task automatic send(input int vals[$], input int gap);
        foreach (vals[i]) begin
            cyc(1'b0, 1'b1, vals[i]);
            idle(gap - 1);
        end
    endtask

    task automatic check_got(input string name, input int expv[$]);
        logic signed [W-1:0] g;
        chk({name, "_count"}, got_q.size(), expv.size());
        foreach (expv[i]) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            chk(name, g, expv[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic signed [W-1:0] g;
        reset     = 1'b1;
        bus.en_in = 1'b0;
        bus.in    = '0;
        model_clear();
        do_reset(2);
        cmp_on = 1'b1;
        idle(1);
        chk("reset_state", {29'd0, bus.state}, 0);
        chk("reset_out", $signed(bus.out), 0);

        // Impulse on an odd sample: -1, 9, 9, -1, 0
        do_reset(2);
        idle(1);
        got_q.delete();
        send('{0, 32, 0, 0, 0, 0, 0, 0, 0, 0}, 5);
        idle(10);
        check_got("imp_odd", '{-1, 9, 9, -1, 0});

        // Impulse on the first sample: 0, 16, 0, 0
        do_reset(2);
        idle(1);
        got_q.delete();
        send('{32, 0, 0, 0, 0, 0, 0, 0}, 5);
        idle(10);
        check_got("imp_even", '{0, 16, 0, 0});

        // DC 125 then DC -128
        do_reset(2);
        idle(1);
        got_q.delete();
        send('{125, 125, 125, 125, 125, 125, 125, 125, 125, 125, 125, 125}, 5);
        idle(8);
        g = got_q[4]; chk("dc_pos_4", g, 125);
        g = got_q[5]; chk("dc_pos_5", g, 125);
        got_q.delete();
        send('{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128}, 5);
        idle(8);
        g = got_q[3]; chk("dc_neg_3", g, -128);
        g = got_q[4]; chk("dc_neg_4", g, -128);

        // Saturation, positive and negative
        do_reset(2);
        idle(1);
        got_q.delete();
        send('{0, -256, 0, 255, 255, 255, 0, -256}, 5);
        idle(8);
        g = got_q[3]; chk("sat_pos", g, 255);
        do_reset(2);
        idle(1);
        got_q.delete();
        send('{0, 255, 0, -256, -256, -256, 0, 255}, 5);
        idle(8);
        g = got_q[3]; chk("sat_neg", g, -256);

        // Reset in the middle of a computation: no output may appear
        do_reset(2);
        idle(1);
        got_q.delete();
        cyc(1'b0, 1'b1, 5);
        idle(4);
        cyc(1'b0, 1'b1, 100);
        idle(2);
        do_reset(2);
        idle(1);
        chk("abort_en_out", {31'd0, bus.en_out}, 0);
        chk("abort_out", $signed(bus.out), 0);
        chk("abort_overrun", {31'd0, bus.overrun}, 0);
        idle(12);
        chk("abort_no_output", got_q.size(), 0);

        // Latency: strobe every 5 clocks with random samples
        do_reset(2);
        idle(1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, $urandom_range(0, 511));
            idle(4);
        end
        idle(8);
        chk("lat_overrun", {31'd0, bus.overrun}, 0);

        // Overrun: three back-to-back strobes with the first on start phase
        do_reset(2);
        idle(1);
        cyc(1'b0, 1'b1, 10);
        idle(4);
        got_q.delete();
        cyc(1'b0, 1'b1, 20);
        cyc(1'b0, 1'b1, 30);
        cyc(1'b0, 1'b1, 40);
        idle(12);
        chk("ovr_one_output", got_q.size(), 1);
        chk("ovr_set", {31'd0, bus.overrun}, 1);
        idle(20);
        chk("ovr_sticky", {31'd0, bus.overrun}, 1);
        do_reset(2);
        idle(1);
        chk("ovr_cleared", {31'd0, bus.overrun}, 0);

        // Random traffic with varying strobe density
        for (int b = 0; b < 10; b++) begin
            int p;
            p = $urandom_range(1, 7);
            if (b == 5) begin
                do_reset(2);
            end
            repeat (60) begin
                if ($urandom_range(1, p) == 1) cyc(1'b0, 1'b1, $urandom_range(0, 511));
                else cyc(1'b0, 1'b0, $urandom_range(0, 511));
            end
        end
        idle(10);
        chk("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
